io_read_buffered: RTL and testbench

- Next-generation memory-mapped I/O read unit for the Octavo datapath.
- Each of PORT_COUNT read ports gets its own parametrised FIFO with a valid/ready producer handshake.
- Port addresses are decoded at stage 1, and an empty-port annul flag goes to the controller.
- The selected FIFO is popped (or peeked) once the instruction is confirmed. Popped/peeked data rides a pipeline and is muxed against RAM read data at the output stage.

---
 rtl/io_read_buffered.sv | 158 +++++++++++++++
 tb/tb_io_read_buffered.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_read_buffered.sv
// Memory-mapped I/O read unit: one FIFO per read port, stage-1 address decode,
// stage-2 pop/peek, and a pipelined output mux of I/O words against RAM data.
module io_read_buffered #(
    parameter int WORD_WIDTH      = 36,
    parameter int ADDR_WIDTH      = 10,
    parameter int PORT_COUNT      = 4,
    parameter int PORT_BASE_ADDR  = 0,
    parameter int FIFO_ADDR_WIDTH = 2,
    parameter int PEEK_ENABLE     = 0,
    parameter int OUT_STAGES      = 2
) (
    input  logic                                     clock,
    input  logic                                     reset_n,
    input  logic [ADDR_WIDTH-1:0]                    addr_1,
    input  logic                                     io_ready_2,
    input  logic [WORD_WIDTH-1:0]                    data_RAM,
    input  logic [PORT_COUNT*WORD_WIDTH-1:0]         in_data,
    input  logic [PORT_COUNT-1:0]                    in_valid,
    output logic [PORT_COUNT-1:0]                    in_ready,
    output logic                                     io_empty_1,
    output logic [PORT_COUNT*(FIFO_ADDR_WIDTH+1)-1:0] fill_level,
    output logic [WORD_WIDTH-1:0]                    data_out,
    output logic                                     underflow_err
);
    localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;
    localparam int CW    = FIFO_ADDR_WIDTH + 1;
    localparam int PW    = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;
    localparam int OW    = ADDR_WIDTH + 1;
    localparam int SPAN  = (PEEK_ENABLE != 0) ? 2 * PORT_COUNT : PORT_COUNT;
    localparam int LAST  = OUT_STAGES - 1;

    logic [WORD_WIDTH-1:0]      mem    [PORT_COUNT][DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr [PORT_COUNT];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr [PORT_COUNT];
    logic [CW-1:0]              count  [PORT_COUNT];

    logic [OW-1:0] offset;
    logic          hit_1, peek_1;
    logic [PW-1:0] port_1;

    // NOTE: combinational blocks use blocking '=' and give every output a default
    // first, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        offset = {1'b0, addr_1} - OW'(PORT_BASE_ADDR);
        hit_1  = (addr_1 >= ADDR_WIDTH'(PORT_BASE_ADDR)) && (offset < OW'(SPAN));
        port_1 = '0;
        peek_1 = 1'b0;
        if (hit_1) begin
            if (PEEK_ENABLE != 0) begin
                port_1 = PW'(offset >> 1);
                peek_1 = offset[0];
            end else begin
                port_1 = PW'(offset);
            end
        end
    end

    assign io_empty_1 = hit_1 && (count[port_1] == '0);

    logic          hit_2, peek_2;
    logic [PW-1:0] port_2;

    // NOTE: clocked state uses non-blocking '<=' so every register samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_2  <= 1'b0;
            peek_2 <= 1'b0;
            port_2 <= '0;
        end else begin
            hit_2  <= hit_1;
            peek_2 <= peek_1;
            port_2 <= port_1;
        end
    end

    logic                  take_2, empty_2, underflow_2;
    logic [WORD_WIDTH-1:0] head_2;
    logic [PORT_COUNT-1:0] push, pop;

    assign take_2      = hit_2 && io_ready_2;
    assign empty_2     = (count[port_2] == '0);
    assign underflow_2 = take_2 && empty_2;
    assign head_2      = underflow_2 ? '0 : mem[port_2][rd_ptr[port_2]];

    // Push is gated by the registered count, so a full FIFO refuses even when popped.
    always_comb begin
        in_ready   = '0;
        push       = '0;
        pop        = '0;
        fill_level = '0;
        for (int p = 0; p < PORT_COUNT; p++) begin
            in_ready[p]             = (count[p] != CW'(DEPTH));
            push[p]                 = in_valid[p] && in_ready[p];
            pop[p]                  = take_2 && !peek_2 && !empty_2 && (port_2 == PW'(p));
            fill_level[p*CW +: CW]  = count[p];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < PORT_COUNT; p++) begin
                rd_ptr[p] <= '0;
                wr_ptr[p] <= '0;
                count[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < PORT_COUNT; p++) begin
                if (push[p]) wr_ptr[p] <= wr_ptr[p] + FIFO_ADDR_WIDTH'(1);
                if (pop[p])  rd_ptr[p] <= rd_ptr[p] + FIFO_ADDR_WIDTH'(1);
                case ({push[p], pop[p]})
                    2'b10:   count[p] <= count[p] + CW'(1);
                    2'b01:   count[p] <= count[p] - CW'(1);
                    default: count[p] <= count[p];
                endcase
            end
        end
    end

    // NOTE: FIFO storage has no reset; the counters decide which words are live,
    // so stale contents are never observed and the array stays plain RAM.
    always_ff @(posedge clock) begin
        for (int p = 0; p < PORT_COUNT; p++) begin
            if (push[p]) mem[p][wr_ptr[p]] <= in_data[p*WORD_WIDTH +: WORD_WIDTH];
        end
    end

    logic [WORD_WIDTH-1:0] pipe_data  [OUT_STAGES];
    logic                  pipe_hit   [OUT_STAGES];
    logic                  pipe_ready [OUT_STAGES];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < OUT_STAGES; s++) begin
                pipe_data[s]  <= '0;
                pipe_hit[s]   <= 1'b0;
                pipe_ready[s] <= 1'b0;
            end
            underflow_err <= 1'b0;
        end else begin
            pipe_data[0]  <= take_2 ? head_2 : '0;
            pipe_hit[0]   <= hit_2;
            pipe_ready[0] <= io_ready_2;
            for (int s = 1; s < OUT_STAGES; s++) begin
                pipe_data[s]  <= pipe_data[s-1];
                pipe_hit[s]   <= pipe_hit[s-1];
                pipe_ready[s] <= pipe_ready[s-1];
            end
            if (underflow_2) underflow_err <= 1'b1;
        end
    end

    always_comb begin
        data_out = '0;
        if (pipe_ready[LAST]) data_out = pipe_hit[LAST] ? pipe_data[LAST] : data_RAM;
    end

endmodule

// File: tb/tb_io_read_buffered.sv
// Directed bench for io_read_buffered: data_out is checked against a cycle-stamped
// scoreboard; a second instance uses the pop/peek address map at a non-zero base.
module tb_io_read_buffered;
    localparam int W       = 36;
    localparam int AW      = 10;
    localparam int PC      = 4;
    localparam int CW      = 3;
    localparam int LAT     = 3;
    localparam int PK_BASE = 8;
    localparam logic [AW-1:0] IDLE = 10'h3F0;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic [AW-1:0]    addr_1 = IDLE, p_addr_1 = IDLE;
    logic             io_ready_2 = 1'b0;
    logic [W-1:0]     data_RAM = '0;
    logic [PC*W-1:0]  in_data = '0;
    logic [PC-1:0]    in_valid = '0, p_in_valid = '0;
    logic [PC-1:0]    in_ready, p_in_ready;
    logic             io_empty_1, p_io_empty_1;
    logic [PC*CW-1:0] fill_level, p_fill_level;
    logic [W-1:0]     data_out, p_data_out;
    logic             underflow_err, p_underflow_err;

    always #5 clock = ~clock;

    io_read_buffered dut (
        .clock(clock), .reset_n(reset_n), .addr_1(addr_1), .io_ready_2(io_ready_2),
        .data_RAM(data_RAM), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .io_empty_1(io_empty_1), .fill_level(fill_level), .data_out(data_out),
        .underflow_err(underflow_err)
    );

    io_read_buffered #(.PEEK_ENABLE(1), .PORT_BASE_ADDR(PK_BASE)) dut_pk (
        .clock(clock), .reset_n(reset_n), .addr_1(p_addr_1), .io_ready_2(io_ready_2),
        .data_RAM(data_RAM), .in_data(in_data), .in_valid(p_in_valid), .in_ready(p_in_ready),
        .io_empty_1(p_io_empty_1), .fill_level(p_fill_level), .data_out(p_data_out),
        .underflow_err(p_underflow_err)
    );

    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    bit           rdy_at [int];
    logic [W-1:0] ram_at [int];
    int           sb_due [$];
    bit           sb_pk  [$];
    logic [W-1:0] sb_exp [$];
    string        sb_tag [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] fl(input logic [PC*CW-1:0] f, input int p);
        return f[p*CW +: CW];
    endfunction

    // Stage-2 readiness and output-stage RAM data are replayed by cycle number.
    always @(posedge clock) begin
        cyc++;
        #1;
        io_ready_2 = rdy_at.exists(cyc) ? rdy_at[cyc] : 1'b0;
        data_RAM   = ram_at.exists(cyc) ? ram_at[cyc] : '0;
    end

    always @(negedge clock) begin
        while (sb_due.size() > 0 && sb_due[0] <= cyc) begin
            check(sb_tag[0], sb_pk[0] ? p_data_out : data_out, sb_exp[0]);
            void'(sb_due.pop_front());
            void'(sb_pk.pop_front());
            void'(sb_exp.pop_front());
            void'(sb_tag.pop_front());
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        addr_1     = IDLE;
        p_addr_1   = IDLE;
        in_valid   = '0;
        p_in_valid = '0;
    endtask

    task automatic issue(input bit pk, input logic [AW-1:0] a, input bit rdy,
                         input logic [W-1:0] ram, input logic [W-1:0] exp, input string tag);
        if (pk) p_addr_1 = a;
        else    addr_1   = a;
        rdy_at[cyc+1]   = rdy;
        ram_at[cyc+LAT] = ram;
        sb_due.push_back(cyc + LAT);
        sb_pk.push_back(pk);
        sb_exp.push_back(exp);
        sb_tag.push_back(tag);
    endtask

    task automatic push(input bit pk, input int p, input logic [W-1:0] d);
        in_data[p*W +: W] = d;
        if (pk) p_in_valid[p] = 1'b1;
        else    in_valid[p]   = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_due.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        if (sb_due.size() > 0) begin
            check("drain timeout", 64'(sb_due.size()), 0);
            sb_due.delete(); sb_pk.delete(); sb_exp.delete(); sb_tag.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("reset in_ready", in_ready, 4'hF);
        check("reset fill_level", fill_level, 0);
        check("reset data_out", data_out, 0);
        check("reset underflow_err", underflow_err, 0);
        reset_n = 1'b1;
        tick();

        // Two pops from port 1 in back-to-back instructions.
        push(0, 1, 36'h11); tick();
        push(0, 1, 36'h22); tick();
        check("t1 fill after pushes", fl(fill_level, 1), 2);
        issue(0, 10'd1, 1'b1, '0, 36'h11, "t1 pop 0x11");
        #1 check("t1 io_empty_1 non-empty", io_empty_1, 0);
        tick();
        issue(0, 10'd1, 1'b1, '0, 36'h22, "t1 pop 0x22");
        tick();
        check("t1 fill after pop 1", fl(fill_level, 1), 1);
        tick();
        check("t1 fill after pop 2", fl(fill_level, 1), 0);
        drain();

        // Empty port, not committed.
        issue(0, 10'd2, 1'b0, 36'h999, '0, "t2 empty port ready=0");
        #1 check("t2 io_empty_1", io_empty_1, 1);
        drain();
        check("t2 underflow_err", underflow_err, 0);
        check("t2 fill unchanged", fill_level, 0);

        // Full FIFO: rejects pushes, including one held across a pop edge.
        for (int i = 0; i < 4; i++) begin
            push(0, 0, 36'hA0 + i); tick();
        end
        check("t3 in_ready full", in_ready[0], 0);
        check("t3 fill full", fl(fill_level, 0), 4);
        push(0, 0, 36'hA4); tick();
        check("t3 fill after rejected push", fl(fill_level, 0), 4);
        issue(0, 10'd0, 1'b1, '0, 36'hA0, "t3 pop A0"); tick();
        push(0, 0, 36'hA4); tick();
        check("t3 in_ready after pop", in_ready[0], 1);
        check("t3 fill after pop", fl(fill_level, 0), 3);
        push(0, 0, 36'hA5); tick();
        check("t3 fill refilled", fl(fill_level, 0), 4);
        issue(0, 10'd0, 1'b1, '0, 36'hA1, "t3 read A1"); tick();
        issue(0, 10'd0, 1'b1, '0, 36'hA2, "t3 read A2"); tick();
        issue(0, 10'd0, 1'b1, '0, 36'hA3, "t3 read A3");
        push(0, 0, 36'hA6); tick();
        check("t3 fill push+pop", fl(fill_level, 0), 3);
        issue(0, 10'd0, 1'b1, '0, 36'hA5, "t3 read A5"); tick();
        issue(0, 10'd0, 1'b1, '0, 36'hA6, "t3 read A6"); tick();
        drain();
        check("t3 fill drained", fill_level, 0);

        // RAM addresses, including the first address past the port range.
        issue(0, 10'h200, 1'b1, 36'h5A5, 36'h5A5, "t5 RAM ready=1"); tick();
        issue(0, 10'h200, 1'b0, 36'h5A5, '0, "t5 RAM ready=0"); tick();
        issue(0, 10'd4, 1'b1, 36'h123, 36'h123, "t5 RAM past ports");
        #1 check("t5 io_empty_1 past ports", io_empty_1, 0);
        drain();

        // Peek twice, then pop, on the peek-enabled instance.
        push(1, 0, 36'hAB); tick();
        check("t4 fill before peek", fl(p_fill_level, 0), 1);
        issue(1, 10'(PK_BASE + 1), 1'b1, '0, 36'hAB, "t4 peek 1"); tick();
        issue(1, 10'(PK_BASE + 1), 1'b1, '0, 36'hAB, "t4 peek 2"); tick();
        issue(1, 10'(PK_BASE), 1'b1, '0, 36'hAB, "t4 pop");
        check("t4 fill after peek 1", fl(p_fill_level, 0), 1);
        tick();
        check("t4 fill after peek 2", fl(p_fill_level, 0), 1);
        tick();
        check("t4 fill after pop", fl(p_fill_level, 0), 0);
        drain();
        check("t4 p_in_ready", p_in_ready, 4'hF);
        check("t4 p_underflow_err", p_underflow_err, 0);
        p_addr_1 = 10'(PK_BASE + 3);
        #1 check("t4 peek addr empty port 1", p_io_empty_1, 1);
        p_addr_1 = 10'(PK_BASE - 1);
        #1 check("t4 below base", p_io_empty_1, 0);
        p_addr_1 = 10'(PK_BASE + 8);
        #1 check("t4 past peek range", p_io_empty_1, 0);
        tick();

        // Underflow, stickiness, then an asynchronous reset mid-flight.
        issue(0, 10'd3, 1'b1, 36'h777, '0, "t6 underflow data");
        tick(); tick();
        check("t6 underflow_err set", underflow_err, 1);
        check("t6 fill unchanged", fl(fill_level, 3), 0);
        drain(); tick(); tick();
        check("t6 underflow sticky", underflow_err, 1);
        for (int i = 0; i < 4; i++) begin
            push(0, 3, 36'hC0 + i); tick();
        end
        check("t6 in_ready full", in_ready[3], 0);
        issue(0, 10'd3, 1'b1, '0, 36'hC0, "t6 in-flight read");
        tick(); tick(); tick();
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6 rst data_out", data_out, 0);
        check("t6 rst underflow_err", underflow_err, 0);
        check("t6 rst in_ready", in_ready, 4'hF);
        check("t6 rst fill_level", fill_level, 0);
        repeat (2) @(posedge clock);
        #1;
        check("t6 data_out held in reset", data_out, 0);
        reset_n = 1'b1;
        tick();
        addr_1 = 10'd3;
        #1 check("t6 contents discarded", io_empty_1, 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
